fetch_req_sched: RTL
====================

Name: fetch_req_sched

Overview:
- Sequences instruction-cache requests for the fetch pipeline.
- Accepts one fetch-group address (NUM_OF_FETCH words) from the PC stage. Assigns it a first_instr_id whose low 2 bits are 0. Splits it into 2..3 doubleword (DW) icache requests with consecutive ids, issued one per cycle over a single ready/valid icache port.
- Owns the fetch generation counter and the in-flight fetch-group credit that keeps the IFQ from overflowing. Sits between the PC stage and the icache request port; the IFQ consumes the tagged responses.

Parameters:
- MAX_INFLIGHT, 16, maximum fetch groups accepted but not yet retired by the IFQ; equals the IFQ depth.
- NUM_OF_FETCH, 4, words per fetch group; from the common package.
- DW_SIZE, 8, bytes per icache response; from the common package.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- fetch_valid  in  1  PC stage presents a fetch address
- fetch_vaddr  in  VADDR_WIDTH  fetch-group start address; bits [1:0] ignored
- fetch_ready  out  1  request accepted this cycle when fetch_valid is also 1
- fetch_id  out  32  first_instr_id assigned to the accepted group; valid in the accept cycle
- ic_req_valid  out  1  icache request valid
- ic_req_ready  in  1  icache accepts the request
- ic_req_vaddr  out  VADDR_WIDTH  DW-aligned request address
- ic_req_id  out  32  request id = first_instr_id + k, k = 0..2
- ic_req_generation  out  32  generation tag of the request
- ifq_retire  in  1  IFQ dequeued one fetch group (pulse)
- stall_in  in  1  IFQ full; no new groups accepted
- flush_in  in  1  redirect; abandon all sequencing
- generation  out  32  current generation, also broadcast to the IFQ
- inflight_cnt  out  $clog2(MAX_INFLIGHT)+1  groups in flight (debug/verification)

Behaviour:

Reset (reset==0, asynchronous):
- state=IDLE; id_ctr=0; generation=0; inflight_cnt=0.
- ic_req_valid=0; fetch_ready=0; all address/id outputs 0.

States:
- IDLE: waiting for a fetch group.
- ISSUE: emitting the DW requests of the current group.

fetch_ready:
- Combinational: 1 iff state==IDLE && !stall_in && !flush_in && inflight_cnt<MAX_INFLIGHT && reset deasserted.

Accept (fetch_valid && fetch_ready at cycle T):
- fetch_id = id_ctr; id_ctr += 4 (mod 2^32).
- Latch base_dw = {fetch_vaddr[MSB:3], 3'b0}.
- Latch n_dw = ((fetch_vaddr[2:0] & 3'b100) + 4*NUM_OF_FETCH - 1)/DW_SIZE + 1, which gives 2 for an 8-byte-aligned address and 3 otherwise.
- Set k=0 and inflight_cnt++; go to ISSUE.
- The first ic_req_valid appears at T+1 (registered outputs).

ISSUE:
- ic_req_valid=1; ic_req_vaddr = base_dw + 8*k; ic_req_id = first_id + k; ic_req_generation = generation.
- Outputs hold stable until ic_req_ready.
- On handshake: k++. When k==n_dw-1 handshakes, go to IDLE. The next accept is possible in that same IDLE cycle at the earliest, i.e. one cycle after the last handshake.

ifq_retire:
- inflight_cnt-- when ifq_retire=1.
- Accept and retire in the same cycle leaves the count unchanged.
- Retire with count 0 is illegal; assertion fires and the count saturates at 0.

flush_in (priority over everything except reset):
- Same cycle: ic_req_valid and fetch_ready forced 0.
- Next edge: generation += 1 (wraps mod 2^32); state=IDLE; inflight_cnt=0; id_ctr unchanged; pending DWs dropped.
- Handshakes in the flush cycle are not counted.

stall_in:
- Blocks new accepts only; a group already in ISSUE completes.

Invariants:
- ic_req_id[1:0] < n_dw.
- ic_req_id[31:2] is constant within a group.
- ic_req_valid never drops without a handshake except on flush or reset.

Decomposition:
- Common package: fetch_req_t (vaddr, id, generation), icache_req_t, and MAX_INFLIGHT's default tied to the IFQ depth constant. Share the last so the IFQ and this block cannot disagree.
- The per-group DW count/address computation is small and stays inline.
- Natural sub-module: fetch_credit_ctr, an up/down saturating counter with flush clear and full flag, reusable for other queue credits.

Test Plan:
1. fetch_vaddr=0x1000, ic_req_ready=1 -> reqs at T+1, T+2: vaddr 0x1000/0x1008, ids 0/1, gen 0; fetch_ready=1 again at T+3; next group id 4.
2. fetch_vaddr=0x1004 -> three reqs 0x1000/0x1008/0x1010 with ids 0,1,2; ic_req_ready low two cycles on the 2nd req -> outputs stable, no duplicate.
3. Accept 16 groups with no ifq_retire -> fetch_ready=0, inflight_cnt=16. One retire -> accept resumes; accept+retire same cycle -> count unchanged.
4. flush_in during 2nd DW of a 3-DW group -> ic_req_valid=0 that cycle, generation 0->1, inflight_cnt=0. Next group issues with gen 1 and id continuing (e.g. 4).
5. reset asserted (0) mid-ISSUE asynchronously -> ic_req_valid drops immediately; after release id=0, generation=0.
6. stall_in=1 while in ISSUE -> current group completes, fetch_ready stays 0 until stall_in=0.

Source files
------------

// File: rtl/fetch_req_sched_pkg.sv
// Shared fetch-path constants and request types, imported by the scheduler and the IFQ.
// MAX_INFLIGHT_DEFAULT is tied to IFQ_DEPTH so the credit limit and the queue depth are always equal.
package fetch_req_sched_pkg;

   localparam int VADDR_WIDTH          = 39;
   localparam int NUM_OF_FETCH         = 4;
   localparam int DW_SIZE              = 8;
   localparam int IFQ_DEPTH            = 16;
   localparam int MAX_INFLIGHT_DEFAULT = IFQ_DEPTH;

   typedef logic [VADDR_WIDTH-1:0] vaddr_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } sched_state_e;

   // Context latched for one fetch group while its DWs are issued
   typedef struct packed {
      vaddr_t      vaddr;
      logic [31:0] id;
      logic [31:0] generation;
   } fetch_req_t;

   typedef struct packed {
      vaddr_t      vaddr;
      logic [31:0] id;
      logic [31:0] generation;
   } icache_req_t;

endpackage

// File: rtl/fetch_req_sched_if.sv
// PC-stage accept handshake and icache request port of the fetch request scheduler.
// master = scheduler side, slave = PC stage / icache side.
interface fetch_req_sched_if;
   import fetch_req_sched_pkg::*;

   logic        fetch_valid;
   vaddr_t      fetch_vaddr;
   logic        fetch_ready;
   logic [31:0] fetch_id;

   logic        ic_req_valid;
   logic        ic_req_ready;
   vaddr_t      ic_req_vaddr;
   logic [31:0] ic_req_id;
   logic [31:0] ic_req_generation;

   modport master (
      input  fetch_valid, fetch_vaddr, ic_req_ready,
      output fetch_ready, fetch_id, ic_req_valid, ic_req_vaddr, ic_req_id, ic_req_generation
   );

   modport slave (
      output fetch_valid, fetch_vaddr, ic_req_ready,
      input  fetch_ready, fetch_id, ic_req_valid, ic_req_vaddr, ic_req_id, ic_req_generation
   );

endinterface

// File: rtl/fetch_req_sched_credit_ctr.sv
// Up/down credit counter: count updates on the next edge, clr wins, simultaneous inc+dec cancel.
// full is combinational; inc is ignored at MAX and dec at zero (dec at zero is a caller error).
module fetch_credit_ctr #(
   parameter int MAX = 16,
   parameter int W   = $clog2(MAX) + 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         full
);

   assign full = (cnt >= W'(MAX));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !dec && !full) begin
         cnt <= cnt + W'(1);
      end else if (dec && !inc && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
      !(dec && !inc && !clr && (cnt == '0)));

endmodule

// File: rtl/fetch_req_sched.sv
// Fetch request scheduler: splits each accepted fetch group into 2-3 DW icache requests, one per cycle.
// First request one cycle after accept; requests hold while ic_req_ready=0; accept blocked by stall, flush or full credit.
module fetch_req_sched
   import fetch_req_sched_pkg::*;
#(
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
   input  logic                          clock,
   input  logic                          reset,
   fetch_req_sched_if.master             req_if,
   input  logic                          ifq_retire,
   input  logic                          stall_in,
   input  logic                          flush_in,
   output logic [31:0]                   generation,
   output logic [$clog2(MAX_INFLIGHT):0] inflight_cnt
);

   localparam int GROUP_BYTES = 4 * NUM_OF_FETCH;

   sched_state_e state_q, state_d;
   logic [31:0]  id_ctr_q, id_ctr_d;
   logic [31:0]  gen_q, gen_d;
   fetch_req_t   grp_q, grp_d;
   logic [1:0]   n_dw_q, n_dw_d;
   logic [1:0]   k_q, k_d;

   logic         accept;
   logic         credit_full;
   logic         last_dw;
   logic [2:0]   first_off;
   logic [1:0]   acc_n_dw;
   icache_req_t  ic_req;
   logic         unused_vaddr_lo;

   assign unused_vaddr_lo = ^req_if.fetch_vaddr[1:0];

   assign req_if.fetch_ready = reset && (state_q == S_IDLE) && !stall_in && !flush_in && !credit_full;
   assign accept             = req_if.fetch_valid && req_if.fetch_ready;
   assign req_if.fetch_id    = id_ctr_q;
   assign generation         = gen_q;

   // Word offset of the group inside its first DW decides whether it spills into a third DW
   assign first_off = {req_if.fetch_vaddr[2], 2'b00};
   assign acc_n_dw  = 2'((int'(first_off) + GROUP_BYTES - 1) / DW_SIZE + 1);
   assign last_dw   = (k_q == (n_dw_q - 2'd1));

   assign ic_req.vaddr      = grp_q.vaddr + vaddr_t'({k_q, 3'b000});
   assign ic_req.id         = grp_q.id + {30'd0, k_q};
   assign ic_req.generation = grp_q.generation;

   assign req_if.ic_req_valid      = (state_q == S_ISSUE) && !flush_in;
   assign req_if.ic_req_vaddr      = ic_req.vaddr;
   assign req_if.ic_req_id         = ic_req.id;
   assign req_if.ic_req_generation = ic_req.generation;

   always_comb begin
      state_d  = state_q;
      id_ctr_d = id_ctr_q;
      gen_d    = gen_q;
      grp_d    = grp_q;
      n_dw_d   = n_dw_q;
      k_d      = k_q;
      if (flush_in) begin
         gen_d   = gen_q + 32'd1;
         state_d = S_IDLE;
         k_d     = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  id_ctr_d         = id_ctr_q + 32'd4;
                  grp_d.vaddr      = {req_if.fetch_vaddr[VADDR_WIDTH-1:3], 3'b000};
                  grp_d.id         = id_ctr_q;
                  grp_d.generation = gen_q;
                  n_dw_d           = acc_n_dw;
                  k_d              = '0;
                  state_d          = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (req_if.ic_req_ready) begin
                  if (last_dw) begin
                     k_d     = '0;
                     state_d = S_IDLE;
                  end else begin
                     k_d = k_q + 2'd1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         id_ctr_q <= '0;
         gen_q    <= '0;
         grp_q    <= '0;
         n_dw_q   <= '0;
         k_q      <= '0;
      end else begin
         state_q  <= state_d;
         id_ctr_q <= id_ctr_d;
         gen_q    <= gen_d;
         grp_q    <= grp_d;
         n_dw_q   <= n_dw_d;
         k_q      <= k_d;
      end
   end

   fetch_credit_ctr #(
      .MAX (MAX_INFLIGHT),
      .W   ($clog2(MAX_INFLIGHT) + 1)
   ) u_credit (
      .clock (clock),
      .reset (reset),
      .clr   (flush_in),
      .inc   (accept),
      .dec   (ifq_retire),
      .cnt   (inflight_cnt),
      .full  (credit_full)
   );

   a_id_in_group: assert property (@(posedge clock) disable iff (!reset)
      req_if.ic_req_valid |-> (req_if.ic_req_id[1:0] < n_dw_q));

   a_valid_holds: assert property (@(posedge clock) disable iff (!reset)
      (req_if.ic_req_valid && !req_if.ic_req_ready) |=> (req_if.ic_req_valid || flush_in));

endmodule
